// File: rtl/gen3_rx_block_scheduler_pkg.sv
// Shared constants, state type and lane-mask helpers for the
// Gen3 receive block scheduler.
package gen3_rx_block_scheduler_pkg;

   localparam int LANES           = 16;
   localparam int BEATS_PER_BLOCK = 4;
   localparam int LOCK_COUNT      = 8;
   localparam int ERR_LIMIT       = 4;
   localparam int PW = $clog2(BEATS_PER_BLOCK);
   localparam int GW = $clog2(LOCK_COUNT + 1);
   localparam int EW = $clog2(ERR_LIMIT + 1);

   localparam logic [1:0] SH_DATA = 2'b10;
   localparam logic [1:0] SH_OS   = 2'b01;

   typedef enum logic [1:0] {
      UNLOCKED,
      LOCKING,
      LOCKED
   } state_e;

   // Unsupported widths fall back to the full link.
   function automatic logic [4:0] lanes_decode(input logic [4:0] cfg);
      logic [4:0] n;
      case (cfg)
         5'd1, 5'd2, 5'd4, 5'd8: n = cfg;
         default:                n = 5'd16;
      endcase
      return n;
   endfunction

   function automatic logic [LANES-1:0] lane_mask(input logic [4:0] n);
      logic [LANES-1:0] m;
      m = '0;
      for (int l = 0; l < LANES; l++) m[l] = (5'(l) < n);
      return m;
   endfunction

   function automatic logic [4*LANES-1:0] byte_mask(input logic [4:0] n);
      logic [LANES-1:0]   lm;
      logic [4*LANES-1:0] m;
      lm = lane_mask(n);
      m  = '0;
      for (int l = 0; l < LANES; l++) m[4*l +: 4] = {4{lm[l]}};
      return m;
   endfunction

   function automatic logic [2*LANES-1:0] sh_mask(input logic [4:0] n);
      logic [LANES-1:0]   lm;
      logic [2*LANES-1:0] m;
      lm = lane_mask(n);
      m  = '0;
      for (int l = 0; l < LANES; l++) m[2*l +: 2] = {2{lm[l]}};
      return m;
   endfunction

endpackage

// File: rtl/gen3_rx_block_scheduler_sh_check.sv
// Combinational sync-header consistency check across the
// active lanes; inactive lanes never affect the verdict.
module gen3_sh_check
   import gen3_rx_block_scheduler_pkg::*;
(
   input  logic [2*LANES-1:0] in_sh,
   input  logic [4:0]         active_lanes,
   output logic               all_data,
   output logic               all_os,
   output logic               good
);

   logic [LANES-1:0] lm;

   assign lm = lane_mask(active_lanes);

   always_comb begin
      all_data = 1'b1;
      all_os   = 1'b1;
      for (int l = 0; l < LANES; l++) begin
         if (lm[l]) begin
            if (in_sh[2*l +: 2] != SH_DATA) all_data = 1'b0;
            if (in_sh[2*l +: 2] != SH_OS)   all_os   = 1'b0;
         end
      end
      good = all_data | all_os;
   end

endmodule

// File: rtl/gen3_rx_block_scheduler.sv
// Gen3 128b/130b receive sequencer: block lock, block phase,
// ordered-set stripping and datapath byte-valid generation.
module gen3_rx_block_scheduler
   import gen3_rx_block_scheduler_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic [4:0]           cfg_lanes,
   input  logic                 in_valid,
   input  logic                 in_block_start,
   input  logic [32*LANES-1:0]  in_data,
   input  logic [2*LANES-1:0]   in_sh,
   output logic [32*LANES-1:0]  dp_data,
   output logic [4*LANES-1:0]   dp_valid,
   output logic [2*LANES-1:0]   dp_sync_header,
   output logic                 os_valid,
   output logic                 os_start,
   output logic                 block_lock,
   output logic                 sh_error
);

   state_e             state_q;
   logic [PW-1:0]      phase_q;
   logic [GW-1:0]      good_cnt_q;
   logic [EW-1:0]      err_cnt_q;
   logic [4:0]         lanes_q;
   logic               blk_emit_q;
   logic               blk_os_q;
   logic [32*LANES-1:0] dp_data_q;
   logic [4*LANES-1:0]  dp_valid_q;
   logic [2*LANES-1:0]  sync_q;
   logic               os_valid_q;
   logic               os_start_q;
   logic               lock_q;
   logic               sh_err_q;

   logic [4:0] cfg_n;
   logic [4:0] lanes_chk;
   logic       all_data;
   logic       all_os;
   logic       good;

   assign cfg_n     = lanes_decode(cfg_lanes);
   assign lanes_chk = (state_q == UNLOCKED) ? cfg_n : lanes_q;

   gen3_sh_check u_sh_check (
      .in_sh        (in_sh),
      .active_lanes (lanes_chk),
      .all_data     (all_data),
      .all_os       (all_os),
      .good         (good)
   );

   logic start_b;
   logic misplaced;
   logic bad_blk;
   logic good_blk;
   logic miss_start;

   assign start_b    = in_valid & in_block_start;
   assign misplaced  = start_b & (phase_q != '0);
   assign bad_blk    = start_b & (~good | misplaced);
   assign good_blk   = start_b & ~bad_blk;
   assign miss_start = in_valid & ~in_block_start & (phase_q == '0);

   logic                emit_now;
   logic                data_now;
   logic                os_now;
   logic [4*LANES-1:0]  dp_valid_d;
   logic                os_valid_d;
   logic                os_start_d;
   logic [2*LANES-1:0]  sync_d;

   // A block is emitted only if it started cleanly while already LOCKED.
   always_comb begin
      emit_now = 1'b0;
      data_now = ~blk_os_q;
      os_now   = blk_os_q;
      if (start_b) begin
         emit_now = good_blk & (state_q == LOCKED);
         data_now = all_data;
         os_now   = all_os;
      end else if (!miss_start) begin
         emit_now = blk_emit_q & (state_q == LOCKED);
      end
      dp_valid_d = '0;
      if (in_valid & emit_now & data_now) dp_valid_d = byte_mask(lanes_q);
      os_valid_d = in_valid & emit_now & os_now;
      os_start_d = os_valid_d & start_b;
      sync_d     = sync_q;
      if (start_b) sync_d = good_blk ? (in_sh & sh_mask(lanes_chk)) : '0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= UNLOCKED;
         phase_q    <= '0;
         good_cnt_q <= '0;
         err_cnt_q  <= '0;
         lanes_q    <= 5'd16;
         blk_emit_q <= 1'b0;
         blk_os_q   <= 1'b0;
         dp_data_q  <= '0;
         dp_valid_q <= '0;
         sync_q     <= '0;
         os_valid_q <= 1'b0;
         os_start_q <= 1'b0;
         lock_q     <= 1'b0;
         sh_err_q   <= 1'b0;
      end else begin
         dp_data_q  <= in_data;
         dp_valid_q <= dp_valid_d;
         os_valid_q <= os_valid_d;
         os_start_q <= os_start_d;
         sync_q     <= sync_d;
         sh_err_q   <= bad_blk;
         if (in_valid) phase_q <= start_b ? PW'(1) : phase_q + PW'(1);
         if (start_b) begin
            blk_emit_q <= emit_now;
            blk_os_q   <= all_os;
         end else if (miss_start) begin
            blk_emit_q <= 1'b0;
         end
         unique case (state_q)
            UNLOCKED: begin
               lanes_q <= cfg_n;
               if (good_blk) begin
                  state_q    <= LOCKING;
                  good_cnt_q <= GW'(1);
               end
            end
            LOCKING: begin
               if (bad_blk | miss_start) begin
                  state_q    <= UNLOCKED;
                  good_cnt_q <= '0;
               end else if (good_blk) begin
                  good_cnt_q <= good_cnt_q + GW'(1);
                  if (good_cnt_q == GW'(LOCK_COUNT - 1)) begin
                     state_q   <= LOCKED;
                     lock_q    <= 1'b1;
                     err_cnt_q <= '0;
                  end
               end
            end
            LOCKED: begin
               if (bad_blk | miss_start) begin
                  if (err_cnt_q == EW'(ERR_LIMIT - 1)) begin
                     state_q    <= UNLOCKED;
                     lock_q     <= 1'b0;
                     err_cnt_q  <= '0;
                     good_cnt_q <= '0;
                  end else begin
                     err_cnt_q <= err_cnt_q + EW'(1);
                  end
               end else if (good_blk) begin
                  err_cnt_q <= '0;
               end
            end
            default: begin
               state_q <= UNLOCKED;
               lock_q  <= 1'b0;
            end
         endcase
      end
   end

   assign dp_data        = dp_data_q;
   assign dp_valid       = dp_valid_q;
   assign dp_sync_header = sync_q;
   assign os_valid       = os_valid_q;
   assign os_start       = os_start_q;
   assign block_lock     = lock_q;
   assign sh_error       = sh_err_q;

endmodule
